// File: rtl/sprite_line_selector.sv
// Per-scanline sprite selector: scans the sprite table during horizontal blanking
// for the next line, then picks the lowest-slot sprite covering each pixel.
module sprite_line_selector #(
   parameter int NUM_SPRITES  = 32,
   parameter int MAX_PER_LINE = 4,
   parameter int SPRITE_SIZE  = 20
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        wr_en,
   input  logic [4:0]  wr_addr,
   input  logic [31:0] wr_data,
   output logic        wr_ready,
   input  logic [9:0]  pixel_x,
   input  logic [9:0]  pixel_y,
   input  logic        video_on,
   output logic [31:0] sprite_datas,
   output logic [9:0]  pixel_x_d,
   output logic [9:0]  pixel_y_d,
   output logic        line_overflow
);

   localparam int          IW        = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
   localparam int          CW        = $clog2(MAX_PER_LINE + 1);
   localparam logic [10:0] SZ        = 11'(SPRITE_SIZE);
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_SPRITES - 1);
   localparam logic [31:0] NO_SPRITE = 32'h0000_0001;

   typedef enum logic {IDLE, SCAN} state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   scan_idx_q, scan_idx_d;
   logic [9:0]      target_y_q, target_y_d;
   logic [31:0]     table_q [NUM_SPRITES];
   logic [31:0]     table_d [NUM_SPRITES];
   logic [31:0]     shadow_q [MAX_PER_LINE];
   logic [31:0]     shadow_d [MAX_PER_LINE];
   logic [CW-1:0]   shadow_cnt_q, shadow_cnt_d;
   logic            shadow_ovf_q, shadow_ovf_d;
   logic [31:0]     active_q [MAX_PER_LINE];
   logic [31:0]     active_d [MAX_PER_LINE];
   logic [CW-1:0]   active_cnt_q, active_cnt_d;
   logic            line_ovf_q, line_ovf_d;
   logic [31:0]     sprite_q, sprite_d;
   logic [9:0]      px_dly_q, py_dly_q;

   logic [31:0]     scan_entry;
   logic [10:0]     scan_y;
   logic [10:0]     target_y11;
   logic            scan_hit;

   // Writes are only accepted while not scanning, so a scan always sees a stable table.
   assign wr_ready   = (state_q == IDLE);
   assign scan_entry = table_q[scan_idx_q];
   assign scan_y     = {1'b0, scan_entry[18:9]};
   assign target_y11 = {1'b0, target_y_q};
   assign scan_hit   = scan_entry[29] && (scan_y <= target_y11) && (target_y11 < scan_y + SZ);

   always_comb begin
      state_d      = state_q;
      scan_idx_d   = scan_idx_q;
      target_y_d   = target_y_q;
      table_d      = table_q;
      shadow_d     = shadow_q;
      shadow_cnt_d = shadow_cnt_q;
      shadow_ovf_d = shadow_ovf_q;
      active_d     = active_q;
      active_cnt_d = active_cnt_q;
      line_ovf_d   = line_ovf_q;

      for (int i = 0; i < NUM_SPRITES; i++) begin
         if (wr_en && wr_ready && (wr_addr == 5'(i))) table_d[i] = wr_data;
      end

      case (state_q)
         IDLE: begin
            if (pixel_x == 10'd640) begin
               state_d      = SCAN;
               scan_idx_d   = '0;
               target_y_d   = (pixel_y >= 10'd524) ? 10'd0 : pixel_y + 10'd1;
               shadow_cnt_d = '0;
               shadow_ovf_d = 1'b0;
            end
         end
         SCAN: begin
            if (scan_hit) begin
               if (shadow_cnt_q < CW'(MAX_PER_LINE)) begin
                  for (int s = 0; s < MAX_PER_LINE; s++) begin
                     if (CW'(s) == shadow_cnt_q) shadow_d[s] = scan_entry;
                  end
                  shadow_cnt_d = shadow_cnt_q + CW'(1);
               end else begin
                  shadow_ovf_d = 1'b1;
               end
            end
            if (scan_idx_q == LAST_IDX) state_d = IDLE;
            else                        scan_idx_d = scan_idx_q + IW'(1);
         end
         default: state_d = IDLE;
      endcase

      // End of line: whatever the shadow holds (even a cut-short scan) becomes the next line.
      if (pixel_x == 10'd799) begin
         state_d      = IDLE;
         active_d     = shadow_q;
         active_cnt_d = shadow_cnt_q;
         line_ovf_d   = shadow_ovf_q;
      end
   end

   always_comb begin
      sprite_d = NO_SPRITE;
      for (int s = MAX_PER_LINE - 1; s >= 0; s--) begin
         if ((CW'(s) < active_cnt_q) &&
             ({1'b0, active_q[s][28:19]} <= {1'b0, pixel_x}) &&
             ({1'b0, pixel_x} < {1'b0, active_q[s][28:19]} + SZ))
            sprite_d = active_q[s];
      end
      if (!video_on) sprite_d = NO_SPRITE;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         scan_idx_q   <= '0;
         target_y_q   <= '0;
         table_q      <= '{default: '0};
         shadow_q     <= '{default: '0};
         shadow_cnt_q <= '0;
         shadow_ovf_q <= 1'b0;
         active_q     <= '{default: '0};
         active_cnt_q <= '0;
         line_ovf_q   <= 1'b0;
         sprite_q     <= NO_SPRITE;
         px_dly_q     <= '0;
         py_dly_q     <= '0;
      end else begin
         state_q      <= state_d;
         scan_idx_q   <= scan_idx_d;
         target_y_q   <= target_y_d;
         table_q      <= table_d;
         shadow_q     <= shadow_d;
         shadow_cnt_q <= shadow_cnt_d;
         shadow_ovf_q <= shadow_ovf_d;
         active_q     <= active_d;
         active_cnt_q <= active_cnt_d;
         line_ovf_q   <= line_ovf_d;
         sprite_q     <= sprite_d;
         px_dly_q     <= pixel_x;
         py_dly_q     <= pixel_y;
      end
   end

   assign sprite_datas  = sprite_q;
   assign pixel_x_d     = px_dly_q;
   assign pixel_y_d     = py_dly_q;
   assign line_overflow = line_ovf_q;

endmodule

// File: tb/tb_sprite_line_selector.sv
// Bench for sprite_line_selector: a line-level behavioural model is checked every
// cycle, plus fixed-position expectations for the directed scenarios.
module tb_sprite_line_selector;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        wr_en = 1'b0;
   logic [4:0]  wr_addr = '0;
   logic [31:0] wr_data = '0;
   logic        wr_ready;
   logic [9:0]  pixel_x = '0;
   logic [9:0]  pixel_y = '0;
   logic        video_on = 1'b0;
   logic [31:0] sprite_datas;
   logic [9:0]  pixel_x_d;
   logic [9:0]  pixel_y_d;
   logic        line_overflow;

   int checks = 0;
   int errors = 0;
   int phase  = 0;
   logic [36:0] wq[$];

   sprite_line_selector dut (
      .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_ready(wr_ready), .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
      .sprite_datas(sprite_datas), .pixel_x_d(pixel_x_d), .pixel_y_d(pixel_y_d),
      .line_overflow(line_overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] mk(input bit en, input int x, input int y, input int off);
      return {2'b00, en, 10'(x), 10'(y), 9'(off)};
   endfunction

   function automatic bit in_span(input int lo, input int v);
      return (v >= lo) && (v < lo + 20);
   endfunction

   // Behavioural model: a line list is built from a table snapshot, committed at end of line.
   logic [31:0] m_table [32];
   logic [31:0] snap [32];
   logic [31:0] act_q[$];
   int          busy_cnt = 0;
   int          tgt = 0;
   bit          act_ovf = 1'b0;

   always @(posedge clk) begin
      int px, py, wa, n, hits;
      bit ve, we, pre_busy, found;
      logic [31:0] wd, e_sprite;
      int e_px, e_py;
      bit e_rdy;
      px = int'(pixel_x); py = int'(pixel_y); ve = video_on; we = wr_en;
      wa = int'(wr_addr); wd = wr_data;
      if (!reset_n) begin
         for (int i = 0; i < 32; i++) begin m_table[i] = '0; snap[i] = '0; end
         busy_cnt = 0; tgt = 0; act_q.delete(); act_ovf = 1'b0;
         e_sprite = 32'h1; e_px = 0; e_py = 0; e_rdy = 1'b1;
      end else begin
         e_sprite = 32'h1;
         found = 1'b0;
         if (ve) begin
            foreach (act_q[s]) begin
               if (!found && in_span(int'(act_q[s][28:19]), px)) begin
                  e_sprite = act_q[s];
                  found = 1'b1;
               end
            end
         end
         pre_busy = busy_cnt > 0;
         if (we && !pre_busy && wa < 32) m_table[wa] = wd;
         if (px == 799) begin
            n = pre_busy ? 32 - busy_cnt : 32;
            busy_cnt = 0;
            act_q.delete();
            hits = 0;
            for (int i = 0; i < n; i++) begin
               if (snap[i][29] && in_span(int'(snap[i][18:9]), tgt)) begin
                  hits++;
                  if (act_q.size() < 4) act_q.push_back(snap[i]);
               end
            end
            act_ovf = hits > 4;
         end else if (pre_busy) begin
            busy_cnt--;
         end else if (px == 640) begin
            snap = m_table;
            tgt = (py == 524) ? 0 : py + 1;
            busy_cnt = 32;
         end
         e_px = px; e_py = py; e_rdy = (busy_cnt == 0);
      end
      #1;
      check("sprite_datas", sprite_datas, e_sprite);
      check("pixel_x_d", 32'(pixel_x_d), 32'(e_px));
      check("pixel_y_d", 32'(pixel_y_d), 32'(e_py));
      check("line_overflow", 32'(line_overflow), 32'(act_ovf));
      check("wr_ready", 32'(wr_ready), 32'(e_rdy));
   end

   task automatic step(input int y, input int x, input bit rst);
      bit acc;
      @(negedge clk);
      pixel_x  = 10'(x);
      pixel_y  = 10'(y);
      video_on = (x < 640) && (y < 480);
      reset_n  = !rst;
      if (wq.size() > 0) begin
         wr_en = 1'b1; wr_addr = wq[0][36:32]; wr_data = wq[0][31:0];
      end else begin
         wr_en = 1'b0;
      end
      if (rst) begin
         #1;
         check("rst_async_sprite", sprite_datas, 32'h1);
         check("rst_async_ready", 32'(wr_ready), 32'h1);
         check("rst_async_ovf", 32'(line_overflow), 32'h0);
      end
      acc = wr_en && wr_ready && reset_n;
      @(posedge clk);
      #2;
      if (acc) void'(wq.pop_front());
   endtask

   task automatic pin(input int y, input int x);
      if (phase == 1) begin
         if (y == 50 && x == 100) check("e3_x100", sprite_datas, 32'h2320_6402);
         if (y == 50 && x == 119) check("e3_x119", sprite_datas, 32'h2320_6402);
         if (y == 50 && x == 99)  check("e3_x99",  sprite_datas, 32'h1);
         if (y == 50 && x == 120) check("e3_x120", sprite_datas, 32'h1);
         if (y == 69 && x == 110) check("e3_y69",  sprite_datas, 32'h2320_6402);
         if (y == 70 && x == 110) check("e3_y70",  sprite_datas, 32'h1);
         if (y == 49 && x == 110) check("e3_y49",  sprite_datas, 32'h1);
      end else if (phase == 2) begin
         if (y == 100 && x == 205) check("overlap_e1", sprite_datas, mk(1, 195, 95, 1));
         if (y == 100 && x == 215) check("overlap_e5", sprite_datas, mk(1, 200, 100, 5));
         if (y == 100 && x == 0)   check("no_ovf_100", 32'(line_overflow), 32'h0);
      end else if (phase == 3) begin
         for (int i = 0; i < 6; i++) begin
            if (y == 10 && x == 300 + 30 * i)
               check("ovf_slot", sprite_datas, (i < 4) ? mk(1, 300 + 30 * i, 10, i) : 32'h1);
         end
         if (y == 10 && x == 0) check("ovf_line10", 32'(line_overflow), 32'h1);
      end else if (phase == 4) begin
         if (y == 119 && x == 645) check("hold_rdy645", 32'(wr_ready), 32'h0);
         if (y == 119 && x == 671) check("hold_rdy671", 32'(wr_ready), 32'h0);
         if (y == 119 && x == 672) check("hold_rdy672", 32'(wr_ready), 32'h1);
         if (y == 120 && x == 505) check("late_wr_120", sprite_datas, 32'h1);
         if (y == 121 && x == 505) check("late_wr_121", sprite_datas, mk(1, 500, 120, 8));
      end else if (phase == 5) begin
         if (y == 0 && x == 55) check("wrap_y0", sprite_datas, mk(1, 50, 0, 9));
      end else if (phase == 6) begin
         if (y == 1 && x == 655) check("rst_ready_after", 32'(wr_ready), 32'h1);
         if (y == 2 && x == 55)  check("rst_line_blank", sprite_datas, 32'h1);
         if (y == 3 && x == 55)  check("rst_table_clear", sprite_datas, 32'h1);
      end
   endtask

   task automatic run_line(input int y, input int wr_at = -1, input logic [36:0] wr_item = '0,
                           input int rst_at = -1);
      for (int x = 0; x < 800; x++) begin
         if (x == wr_at) wq.push_back(wr_item);
         step(y, x, x == rst_at);
         pin(y, x);
      end
   endtask

   initial begin
      int y_base;
      repeat (3) @(posedge clk);
      #2;
      check("reset_sprite", sprite_datas, 32'h1);
      check("reset_ready", 32'(wr_ready), 32'h1);
      check("reset_px_d", 32'(pixel_x_d), 32'h0);
      check("reset_ovf", 32'(line_overflow), 32'h0);

      phase = 1;
      run_line(48, 0, {5'd3, mk(1, 100, 50, 2)});
      for (int y = 49; y <= 71; y++) run_line(y);

      phase = 2;
      wq.push_back({5'd1, mk(1, 195, 95, 1)});
      wq.push_back({5'd5, mk(1, 200, 100, 5)});
      run_line(99);
      run_line(100);

      phase = 3;
      for (int i = 0; i < 6; i++) wq.push_back({5'(i), mk(1, 300 + 30 * i, 10, i)});
      run_line(9);
      run_line(10);

      phase = 4;
      run_line(119, 645, {5'd8, mk(1, 500, 120, 8)});
      run_line(120);
      run_line(121);

      phase = 5;
      run_line(524, 0, {5'd9, mk(1, 50, 0, 9)});
      run_line(0);

      phase = 6;
      run_line(1, -1, '0, 650);
      run_line(2);
      run_line(3);

      phase = 7;
      for (int r = 0; r < 6; r++) begin
         y_base = $urandom_range(150, 450);
         for (int i = 0; i < 32; i++)
            wq.push_back({5'(i), mk($urandom_range(0, 3) != 0, $urandom_range(0, 639),
                                    y_base - 40 + $urandom_range(0, 42), $urandom_range(0, 511))});
         run_line(y_base - 1);
         run_line(y_base, $urandom_range(40, 600),
                  {5'($urandom_range(0, 31)), mk(1, $urandom_range(0, 639), y_base + 1, 7)});
         run_line(y_base + 1);
      end

      check("write_drain", 32'(wq.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
